// File: rtl/alu_if.sv
// ALU operand/result bundle between decode and the ALU.
// master drives operands/opcode, slave returns the result.
interface alu_if #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int OP_BIT_WIDTH   = 5
);
    logic [DATA_BIT_WIDTH-1:0] src1;
    logic [DATA_BIT_WIDTH-1:0] src2;
    logic [OP_BIT_WIDTH-1:0]   opcode;
    logic [DATA_BIT_WIDTH-1:0] data_out;

    modport master (
        output src1,
        output src2,
        output opcode,
        input  data_out
    );

    modport slave (
        input  src1,
        input  src2,
        input  opcode,
        output data_out
    );
endinterface

// File: rtl/alu.sv
// Single-cycle integer ALU with a registered result.
// Define ALU_SIGNED_CMP_EN for signed LT/LTE/GTE/GT (unsigned otherwise).
module alu #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int OP_BIT_WIDTH   = 5
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);
    localparam int W = DATA_BIT_WIDTH;
    localparam int H = DATA_BIT_WIDTH / 2;

    localparam logic [OP_BIT_WIDTH-1:0] OP_ADD  = OP_BIT_WIDTH'(0);
    localparam logic [OP_BIT_WIDTH-1:0] OP_SUB  = OP_BIT_WIDTH'(1);
    localparam logic [OP_BIT_WIDTH-1:0] OP_AND  = OP_BIT_WIDTH'(2);
    localparam logic [OP_BIT_WIDTH-1:0] OP_OR   = OP_BIT_WIDTH'(3);
    localparam logic [OP_BIT_WIDTH-1:0] OP_XOR  = OP_BIT_WIDTH'(4);
    localparam logic [OP_BIT_WIDTH-1:0] OP_NAND = OP_BIT_WIDTH'(5);
    localparam logic [OP_BIT_WIDTH-1:0] OP_NOR  = OP_BIT_WIDTH'(6);
    localparam logic [OP_BIT_WIDTH-1:0] OP_XNOR = OP_BIT_WIDTH'(7);
    localparam logic [OP_BIT_WIDTH-1:0] OP_F    = OP_BIT_WIDTH'(8);
    localparam logic [OP_BIT_WIDTH-1:0] OP_EQ   = OP_BIT_WIDTH'(9);
    localparam logic [OP_BIT_WIDTH-1:0] OP_LT   = OP_BIT_WIDTH'(10);
    localparam logic [OP_BIT_WIDTH-1:0] OP_LTE  = OP_BIT_WIDTH'(11);
    localparam logic [OP_BIT_WIDTH-1:0] OP_T    = OP_BIT_WIDTH'(12);
    localparam logic [OP_BIT_WIDTH-1:0] OP_NE   = OP_BIT_WIDTH'(13);
    localparam logic [OP_BIT_WIDTH-1:0] OP_GTE  = OP_BIT_WIDTH'(14);
    localparam logic [OP_BIT_WIDTH-1:0] OP_GT   = OP_BIT_WIDTH'(15);
    localparam logic [OP_BIT_WIDTH-1:0] OP_MVHI = OP_BIT_WIDTH'(16);

    logic [W-1:0] data_out_d;
    logic [W-1:0] data_out_q;
    logic         eq;
    logic         lt;

    // Shared compare primitives; ordering compares derive from eq/lt.
    always_comb begin
        eq = (bus.src1 == bus.src2);
`ifdef ALU_SIGNED_CMP_EN
        lt = ($signed(bus.src1) < $signed(bus.src2));
`else
        lt = (bus.src1 < bus.src2);
`endif
    end

    // Result select; compares zero-extend into bit 0.
    always_comb begin
        data_out_d = '0;
        case (bus.opcode)
            OP_ADD:  data_out_d = bus.src1 + bus.src2;
            OP_SUB:  data_out_d = bus.src1 - bus.src2;
            OP_AND:  data_out_d = bus.src1 & bus.src2;
            OP_OR:   data_out_d = bus.src1 | bus.src2;
            OP_XOR:  data_out_d = bus.src1 ^ bus.src2;
            OP_NAND: data_out_d = ~(bus.src1 & bus.src2);
            OP_NOR:  data_out_d = ~(bus.src1 | bus.src2);
            OP_XNOR: data_out_d = ~(bus.src1 ^ bus.src2);
            OP_F:    data_out_d = '0;
            OP_EQ:   data_out_d = {{(W-1){1'b0}}, eq};
            OP_LT:   data_out_d = {{(W-1){1'b0}}, lt};
            OP_LTE:  data_out_d = {{(W-1){1'b0}}, lt | eq};
            OP_T:    data_out_d = {{(W-1){1'b0}}, 1'b1};
            OP_NE:   data_out_d = {{(W-1){1'b0}}, ~eq};
            OP_GTE:  data_out_d = {{(W-1){1'b0}}, ~lt};
            OP_GT:   data_out_d = {{(W-1){1'b0}}, ~(lt | eq)};
            OP_MVHI: data_out_d = {bus.src2[H-1:0], {H{1'b0}}};
            default: data_out_d = '0;
        endcase
    end

    // Capture the result every edge; reset clears it immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu.
// Expected compare values follow ALU_SIGNED_CMP_EN.
module tb_alu;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    alu_if #(.DATA_BIT_WIDTH(32), .OP_BIT_WIDTH(5)) bus ();

    alu #(.DATA_BIT_WIDTH(32), .OP_BIT_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op);
        @(negedge clk);
        bus.src1   = a;
        bus.src2   = b;
        bus.opcode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] op,
                       input logic [31:0] exp);
        step(a, b, op);
        check(tag, bus.data_out, exp);
    endtask

    initial begin
        logic [31:0] lt_m1_1;
        tests = 0;
        fails = 0;
`ifdef ALU_SIGNED_CMP_EN
        lt_m1_1 = 32'd1;
`else
        lt_m1_1 = 32'd0;
`endif
        reset      = 1'b1;
        bus.src1   = 32'd10;
        bus.src2   = 32'd8;
        bus.opcode = 5'd0;
        #1;
        check("reset_async", bus.data_out, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.data_out, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_no_capture", bus.data_out, 32'd0);
        @(posedge clk);
        #1;
        check("first_add", bus.data_out, 32'd18);

        run("sub",  32'd10, 32'd8, 5'd1,  32'd2);
        run("and",  32'd10, 32'd8, 5'd2,  32'd8);
        run("or",   32'd10, 32'd8, 5'd3,  32'd10);
        run("xor",  32'd10, 32'd8, 5'd4,  32'd2);
        run("nand", 32'd10, 32'd8, 5'd5,  32'hFFFF_FFF7);
        run("nor",  32'd10, 32'd8, 5'd6,  32'hFFFF_FFF5);
        run("xnor", 32'd10, 32'd8, 5'd7,  32'hFFFF_FFFD);
        run("f",    32'd10, 32'd8, 5'd8,  32'd0);
        run("eq",   32'd10, 32'd8, 5'd9,  32'd0);
        run("lt",   32'd10, 32'd8, 5'd10, 32'd0);
        run("lte",  32'd10, 32'd8, 5'd11, 32'd0);
        run("t",    32'd10, 32'd8, 5'd12, 32'd1);
        run("ne",   32'd10, 32'd8, 5'd13, 32'd1);
        run("gte",  32'd10, 32'd8, 5'd14, 32'd1);
        run("gt",   32'd10, 32'd8, 5'd15, 32'd1);
        run("mvhi", 32'd10, 32'd8, 5'd16, 32'h0008_0000);

        run("eq_same",  32'h1234, 32'h1234, 5'd9,  32'd1);
        run("lte_same", 32'h1234, 32'h1234, 5'd11, 32'd1);
        run("gte_same", 32'h1234, 32'h1234, 5'd14, 32'd1);
        run("lt_same",  32'h1234, 32'h1234, 5'd10, 32'd0);
        run("gt_same",  32'h1234, 32'h1234, 5'd15, 32'd0);
        run("ne_same",  32'h1234, 32'h1234, 5'd13, 32'd0);
        run("add_wrap", 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
        run("sub_wrap", 32'd0, 32'd1, 5'd1, 32'hFFFF_FFFF);

        run("lt_m1_1",  32'hFFFF_FFFF, 32'd1, 5'd10, lt_m1_1);
        run("gt_m1_1",  32'hFFFF_FFFF, 32'd1, 5'd15, lt_m1_1 ^ 32'd1);
        run("lte_m1_1", 32'hFFFF_FFFF, 32'd1, 5'd11, lt_m1_1);
        run("gte_m1_1", 32'hFFFF_FFFF, 32'd1, 5'd14, lt_m1_1 ^ 32'd1);

        run("op17", 32'h5555_AAAA, 32'h0F0F_F0F0, 5'd17, 32'd0);
        run("op31", 32'h5555_AAAA, 32'h0F0F_F0F0, 5'd31, 32'd0);
        run("mvhi2", 32'hDEAD_BEEF, 32'hABCD_1234, 5'd16, 32'h1234_0000);

        run("add_pre_rst", 32'd10, 32'd8, 5'd0, 32'd18);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_async", bus.data_out, 32'd0);
        bus.src1 = 32'd7;
        bus.src2 = 32'd5;
        @(posedge clk);
        #1;
        check("rst_mid_hold", bus.data_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_release", bus.data_out, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_capture", bus.data_out, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
